// File: rtl/adsb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adsb_pkg
//  Description : Shared ADS-B constants and types for the Mode S
//                extended-squitter transmit path.
//  Revision    : 1.0 - initial release
// ============================================================================
package adsb_pkg;

    // Full extended-squitter length; short messages occupy the upper bits.
    localparam int adsb_message_width       = 112;
    localparam int adsb_short_message_width = 56;

    // Preamble: 16 half-microsecond chips, pulses on chips 0, 2, 7 and 9.
    // Chip 0 is bit 15, so the pattern reads left to right in transmit order.
    localparam int          adsb_preamble_chips   = 16;
    localparam logic [15:0] adsb_preamble_pattern = 16'b1010000101000000;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_DATA     = 2'd2,
        S_GAP      = 2'd3
    } adsb_mod_state_t;

endpackage : adsb_pkg
`default_nettype wire

// File: rtl/adsb_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : adsb_modulator
//  Description : Mode S extended-squitter PPM transmitter. Latches a 56/112
//                bit message and emits preamble, data chips and an inter-
//                message gap as baseband I/Q samples, one per Sample_tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module adsb_modulator
    import adsb_pkg::*;
#(
    parameter int DAC_WIDTH        = 16,
    parameter int SAMPLES_PER_CHIP = 1,
    parameter int AMPLITUDE        = 2**(DAC_WIDTH-2),
    parameter int GAP_CHIPS        = 8
) (
    input  logic                          Data_clk,
    input  logic                          Data_rst,
    input  logic                          Sample_tick,
    input  logic                          Msg_valid,
    output logic                          Msg_ready,
    input  logic                          Msg_long,
    input  logic [adsb_message_width-1:0] Msg_data,
    output logic                          Dac_valid,
    output logic signed [DAC_WIDTH-1:0]   Dac_data_i,
    output logic signed [DAC_WIDTH-1:0]   Dac_data_q,
    output logic                          Busy,
    output logic                          Msg_done
);

    localparam int c_CHIP_W = $clog2(2*adsb_message_width + 1);
    localparam int c_SAMP_W = $clog2(SAMPLES_PER_CHIP) + 1;

    localparam logic [c_SAMP_W-1:0] c_SAMP_LAST  = c_SAMP_W'(SAMPLES_PER_CHIP - 1);
    localparam logic [c_CHIP_W-1:0] c_PRE_LAST   = c_CHIP_W'(adsb_preamble_chips - 1);
    localparam logic [c_CHIP_W-1:0] c_LONG_LAST  = c_CHIP_W'(2*adsb_message_width - 1);
    localparam logic [c_CHIP_W-1:0] c_SHORT_LAST = c_CHIP_W'(2*adsb_short_message_width - 1);
    localparam logic [c_CHIP_W-1:0] c_GAP_LAST   = c_CHIP_W'(GAP_CHIPS - 1);
    localparam logic signed [DAC_WIDTH-1:0] c_AMP = DAC_WIDTH'(AMPLITUDE);

    adsb_mod_state_t                 r_state;
    logic [c_CHIP_W-1:0]             r_chip_idx;
    logic [c_SAMP_W-1:0]             r_samp_cnt;
    logic [adsb_message_width-1:0]   r_shift;
    logic                            r_long;
    logic                            r_ready;
    logic                            r_dac_valid;
    logic signed [DAC_WIDTH-1:0]     r_dac_i;
    logic                            r_done;

    logic                            w_chip_end;
    logic [3:0]                      w_pre_idx;
    logic [c_CHIP_W-1:0]             w_data_last;
    logic                            w_pulse;

    assign w_chip_end  = (r_samp_cnt == c_SAMP_LAST);
    assign w_pre_idx   = 4'(adsb_preamble_chips - 1) - r_chip_idx[3:0];
    assign w_data_last = r_long ? c_LONG_LAST : c_SHORT_LAST;

    // Pulse level of the chip currently on air; the current data bit is always
    // the MSB of the shift register, so an odd chip is simply its complement.
    always_comb begin
        w_pulse = 1'b0;
        case (r_state)
            S_PREAMBLE: w_pulse = adsb_preamble_pattern[w_pre_idx];
            S_DATA:     w_pulse = r_shift[adsb_message_width-1] ^ r_chip_idx[0];
            default:    w_pulse = 1'b0;
        endcase
    end

    // Transmit FSM, chip/sample counters, message shift register and all outputs.
    always_ff @(posedge Data_clk) begin
        if (Data_rst) begin
            r_state     <= S_IDLE;
            r_chip_idx  <= '0;
            r_samp_cnt  <= '0;
            r_shift     <= '0;
            r_long      <= 1'b0;
            r_ready     <= 1'b0;
            r_dac_valid <= 1'b0;
            r_dac_i     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_dac_valid <= Sample_tick;
            r_dac_i     <= (Sample_tick && w_pulse) ? c_AMP : '0;
            r_done      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // Ready rises one cycle after returning to idle, so a request
                    // held through Msg_done is taken on the following cycle.
                    if (Msg_valid && r_ready) begin
                        r_shift    <= Msg_data;
                        r_long     <= Msg_long;
                        r_chip_idx <= '0;
                        r_samp_cnt <= '0;
                        r_ready    <= 1'b0;
                        r_state    <= S_PREAMBLE;
                    end else begin
                        r_ready    <= 1'b1;
                    end
                end

                default: begin
                    if (Sample_tick) begin
                        if (!w_chip_end) begin
                            r_samp_cnt <= r_samp_cnt + 1'b1;
                        end else begin
                            r_samp_cnt <= '0;
                            r_chip_idx <= r_chip_idx + 1'b1;
                            case (r_state)
                                S_PREAMBLE: begin
                                    if (r_chip_idx == c_PRE_LAST) begin
                                        r_chip_idx <= '0;
                                        r_state    <= S_DATA;
                                    end
                                end
                                S_DATA: begin
                                    // Second chip of a bit done: advance to the next bit.
                                    if (r_chip_idx[0]) begin
                                        r_shift <= {r_shift[adsb_message_width-2:0], 1'b0};
                                    end
                                    if (r_chip_idx == w_data_last) begin
                                        r_chip_idx <= '0;
                                        r_state    <= S_GAP;
                                    end
                                end
                                default: begin
                                    if (r_chip_idx == c_GAP_LAST) begin
                                        r_chip_idx <= '0;
                                        r_done     <= 1'b1;
                                        r_state    <= S_IDLE;
                                    end
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign Msg_ready  = r_ready;
    assign Busy       = (r_state != S_IDLE);
    assign Dac_valid  = r_dac_valid;
    assign Dac_data_i = r_dac_i;
    assign Dac_data_q = '0;
    assign Msg_done   = r_done;

endmodule : adsb_modulator
`default_nettype wire

// File: tb/tb_adsb_modulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adsb_modulator
//  Description : Self-checking bench for adsb_modulator. Expected sample
//                streams come from a chip-list model of the PPM format.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adsb_modulator;

    localparam int c_AMP = 2**14;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               tick = 1'b0;
    logic               msg_valid = 1'b0;
    logic               msg_long = 1'b0;
    logic [111:0]       msg_data = '0;
    logic               msg_ready, dac_valid, busy, done;
    logic signed [15:0] dac_i, dac_q;

    logic               tick4 = 1'b0;
    logic               valid4 = 1'b0;
    logic               ready4, dac_valid4, busy4, done4;
    logic signed [15:0] dac_i4, dac_q4;

    int tests_run    = 0;
    int tests_failed = 0;

    int got[$];
    int exp_q[$];
    int busy_cnt, done_cnt;
    bit timed_out, q_bad;

    always #5 clk = ~clk;

    adsb_modulator dut (
        .Data_clk(clk), .Data_rst(rst), .Sample_tick(tick),
        .Msg_valid(msg_valid), .Msg_ready(msg_ready), .Msg_long(msg_long),
        .Msg_data(msg_data), .Dac_valid(dac_valid), .Dac_data_i(dac_i),
        .Dac_data_q(dac_q), .Busy(busy), .Msg_done(done)
    );

    adsb_modulator #(.SAMPLES_PER_CHIP(4)) dut4 (
        .Data_clk(clk), .Data_rst(rst), .Sample_tick(tick4),
        .Msg_valid(valid4), .Msg_ready(ready4), .Msg_long(msg_long),
        .Msg_data(msg_data), .Dac_valid(dac_valid4), .Dac_data_i(dac_i4),
        .Dac_data_q(dac_q4), .Busy(busy4), .Msg_done(done4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: list of chips (preamble, Manchester-style bit pairs, gap),
    // each expanded into spc samples of amplitude or zero.
    function automatic void build_expected(input logic [111:0] m, input bit lng, input int spc);
        bit          chips[$];
        logic [15:0] pre = 16'b1010000101000000;
        int          nbits = lng ? 112 : 56;
        for (int i = 0; i < 16; i++) chips.push_back(pre[15-i]);
        for (int b = 0; b < nbits; b++) begin
            chips.push_back(m[111-b]);
            chips.push_back(!m[111-b]);
        end
        for (int i = 0; i < 8; i++) chips.push_back(1'b0);
        foreach (chips[k])
            for (int s = 0; s < spc; s++) exp_q.push_back(chips[k] ? c_AMP : 0);
    endfunction

    function automatic int first_diff();
        int n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got[i] !== exp_q[i]) return i;
        if (got.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic int got_at(input int i);
        return (i >= 0 && i < got.size()) ? got[i] : -1;
    endfunction

    function automatic int exp_at(input int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i] : -1;
    endfunction

    // Offer one message to the SPC=1 instance and record its whole transmission.
    task automatic send1(input logic [111:0] m, input bit lng);
        int w = 0;
        int cyc = 0;
        got.delete();
        busy_cnt = 0; done_cnt = 0; timed_out = 1'b0; q_bad = 1'b0;
        msg_data = m; msg_long = lng; msg_valid = 1'b1; tick = 1'b0;
        while (!msg_ready && w < 20) begin step(); w++; end
        step();
        msg_valid = 1'b0;
        tick = 1'b1;
        while (cyc < 400) begin
            if (busy) busy_cnt++;
            step();
            cyc++;
            if (dac_valid) begin
                got.push_back(int'(dac_i));
                if (dac_q !== 16'sd0) q_bad = 1'b1;
            end
            if (done) begin done_cnt++; break; end
        end
        if (cyc >= 400) timed_out = 1'b1;
        tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b1;
        step(); step();
        tests_run++;
        if ({msg_ready, dac_valid, busy, done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: ready/valid/busy/done got %b want 0000",
                     {msg_ready, dac_valid, busy, done});
        end
        tests_run++;
        if (dac_i !== 16'sd0 || dac_q !== 16'sd0) begin
            tests_failed++;
            $display("FAIL reset_data: I=%0d Q=%0d want 0 0", dac_i, dac_q);
        end
        rst = 1'b0;
        step(); step(); step();
        tests_run++;
        if ({msg_ready, dac_valid, busy, done} !== 4'b1100 || dac_i !== 16'sd0 || dac_q !== 16'sd0) begin
            tests_failed++;
            $display("FAIL idle_ticks: ready/valid/busy/done=%b I=%0d Q=%0d want 1100 0 0",
                     {msg_ready, dac_valid, busy, done}, dac_i, dac_q);
        end
        tick = 1'b0;
        step();
    endtask

    task automatic test_long();
        logic [111:0] m = 112'h8D4840D6202CC371C32CE0576098;
        int d;
        send1(m, 1'b1);
        exp_q.delete();
        build_expected(m, 1'b1, 1);
        tests_run++;
        if (timed_out !== 1'b0 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL long_done: timed_out=%0d done_count=%0d want 0 1", timed_out, done_cnt);
        end
        tests_run++;
        if (busy_cnt !== 248) begin
            tests_failed++;
            $display("FAIL long_busy: busy ticks %0d want 248", busy_cnt);
        end
        d = first_diff();
        tests_run++;
        if (d !== -1) begin
            tests_failed++;
            $display("FAIL long_samples: idx %0d got %0d want %0d (sizes %0d/%0d)",
                     d, got_at(d), exp_at(d), got.size(), exp_q.size());
        end
        tests_run++;
        if (q_bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL long_q: nonzero Q seen, got 1 want 0");
        end
        step();
        tests_run++;
        if (done !== 1'b0 || msg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL long_after: done=%0d ready=%0d want 0 1", done, msg_ready);
        end
    endtask

    task automatic test_short();
        logic [111:0] m = {56'h5D4840D6DA5F0B, 56'hA5A5A5A5A5A5A5};
        int d;
        send1(m, 1'b0);
        exp_q.delete();
        build_expected(m, 1'b0, 1);
        tests_run++;
        if (timed_out !== 1'b0 || busy_cnt !== 136 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL short_busy: timeout=%0d busy=%0d done=%0d want 0 136 1",
                     timed_out, busy_cnt, done_cnt);
        end
        d = first_diff();
        tests_run++;
        if (d !== -1) begin
            tests_failed++;
            $display("FAIL short_samples: idx %0d got %0d want %0d (sizes %0d/%0d)",
                     d, got_at(d), exp_at(d), got.size(), exp_q.size());
        end
    endtask

    task automatic test_random();
        logic [127:0] r;
        bit           lng;
        int           d;
        for (int n = 0; n < 6; n++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            lng = 1'($urandom_range(0, 1));
            send1(r[111:0], lng);
            exp_q.delete();
            build_expected(r[111:0], lng, 1);
            d = first_diff();
            tests_run++;
            if (d !== -1 || busy_cnt !== (lng ? 248 : 136) || timed_out !== 1'b0) begin
                tests_failed++;
                $display("FAIL random_%0d: idx %0d got %0d want %0d busy %0d timeout %0d",
                         n, d, got_at(d), exp_at(d), busy_cnt, timed_out);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] ra = {$urandom(), $urandom(), $urandom(), $urandom()};
        logic [127:0] rb = {$urandom(), $urandom(), $urandom(), $urandom()};
        int  w = 0, cyc = 0, d;
        int  done_cyc = -1, acc_cyc = -1, ndone = 0;
        bit  ready_at_done = 1'b1;
        got.delete();
        msg_data = ra[111:0]; msg_long = 1'b0; msg_valid = 1'b1; tick = 1'b0;
        while (!msg_ready && w < 20) begin step(); w++; end
        step();
        msg_data = rb[111:0];
        tick = 1'b1;
        while (cyc < 600) begin
            if (msg_valid && msg_ready && acc_cyc < 0) acc_cyc = cyc;
            step();
            cyc++;
            if (acc_cyc >= 0) msg_valid = 1'b0;
            if (dac_valid) got.push_back(int'(dac_i));
            if (done) begin
                ndone++;
                if (ndone == 1) begin done_cyc = cyc; ready_at_done = msg_ready; end
                else break;
            end
        end
        tick = 1'b0;
        msg_valid = 1'b0;
        exp_q.delete();
        build_expected(ra[111:0], 1'b0, 1);
        exp_q.push_back(0);
        exp_q.push_back(0);
        build_expected(rb[111:0], 1'b0, 1);
        tests_run++;
        if (ndone !== 2 || ready_at_done !== 1'b0 || acc_cyc !== done_cyc + 1) begin
            tests_failed++;
            $display("FAIL b2b_accept: dones=%0d ready_at_done=%0d accept_cyc=%0d want 2 0 %0d",
                     ndone, ready_at_done, acc_cyc, done_cyc + 1);
        end
        d = first_diff();
        tests_run++;
        if (d !== -1) begin
            tests_failed++;
            $display("FAIL b2b_samples: idx %0d got %0d want %0d (sizes %0d/%0d)",
                     d, got_at(d), exp_at(d), got.size(), exp_q.size());
        end
        step();
    endtask

    task automatic test_reset_mid();
        int w = 0, nbusy = 0, ndone = 0, nnz = 0;
        msg_data = 112'h8D4840D6202CC371C32CE0576098; msg_long = 1'b1;
        msg_valid = 1'b1; tick = 1'b0;
        while (!msg_ready && w < 20) begin step(); w++; end
        step();
        msg_valid = 1'b0;
        tick = 1'b1;
        for (int i = 0; i < 60; i++) step();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_pre: busy=%0d want 1", busy);
        end
        rst = 1'b1;
        step();
        tests_run++;
        if ({busy, dac_valid, done, msg_ready} !== 4'b0000 || dac_i !== 16'sd0) begin
            tests_failed++;
            $display("FAIL midrst_out: busy/valid/done/ready=%b I=%0d want 0000 0",
                     {busy, dac_valid, done, msg_ready}, dac_i);
        end
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (busy) nbusy++;
            if (done) ndone++;
            if (dac_valid && dac_i !== 16'sd0) nnz++;
        end
        tests_run++;
        if (nbusy !== 0 || ndone !== 0 || nnz !== 0) begin
            tests_failed++;
            $display("FAIL midrst_drop: busy=%0d done=%0d nonzero=%0d want 0 0 0", nbusy, ndone, nnz);
        end
        tick = 1'b0;
        step();
    endtask

    task automatic test_slow();
        logic [111:0] m = 112'h8D4840D6202CC371C32CE0576098;
        int  w = 0, cyc = 0, vio = 0, d;
        bit  prev;
        bit  to = 1'b1;
        got.delete();
        msg_data = m; msg_long = 1'b1; valid4 = 1'b1; tick4 = 1'b0;
        while (!ready4 && w < 20) begin step(); w++; end
        step();
        valid4 = 1'b0;
        while (cyc < 4000) begin
            tick4 = (cyc % 3 == 0);
            prev = tick4;
            step();
            cyc++;
            if (dac_valid4 !== prev) vio++;
            if (dac_valid4) got.push_back(int'(dac_i4));
            if (done4) begin to = 1'b0; break; end
        end
        tick4 = 1'b0;
        exp_q.delete();
        build_expected(m, 1'b1, 4);
        tests_run++;
        if (to !== 1'b0 || got.size() !== 992) begin
            tests_failed++;
            $display("FAIL slow_count: timeout=%0d samples=%0d want 0 992", to, got.size());
        end
        d = first_diff();
        tests_run++;
        if (d !== -1) begin
            tests_failed++;
            $display("FAIL slow_samples: idx %0d got %0d want %0d", d, got_at(d), exp_at(d));
        end
        tests_run++;
        if (vio !== 0) begin
            tests_failed++;
            $display("FAIL slow_valid: strobe violations %0d want 0", vio);
        end
    endtask

    initial begin
        test_reset();
        test_long();
        test_short();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_slow();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_adsb_modulator
`default_nettype wire
